// File: rtl/instr_exec_unit.sv
// ----------------------------------------------------------------------------
// instr_exec_unit
//
// Reads instructions from the instruction register and executes them.
// A start pulse begins a run over a range of addresses. The run fetches each
// instruction, executes it, and presents the result on a valid/ready stream.
// DIV and MOD go through a 32-step restoring divider. Every other opcode
// completes in a single EXEC cycle.
//
// Instruction word layout: {opc[2:0], op_a[OP_W-1:0], op_b[OP_W-1:0]}
//   opc: 0 ZERO, 1 PASSA, 2 PASSB, 3 ADD, 4 SUB, 5 MULT, 6 DIV, 7 MOD
//
// Ports
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   start            begin a run (only sampled while idle)
//   first_addr       first instruction address of the run
//   count            number of instructions in the run (0..2**ADDR_W)
//   read_pointer     address presented to the instruction register
//   instruction_word instruction at read_pointer (combinational read)
//   res_valid        result available
//   res_ready        consumer accepts the result
//   res_data         signed result, RES_W bits
//   res_addr         address of the instruction that produced res_data
//   res_err          divide-by-zero flag, qualified by res_valid
//   busy             high whenever a run is in progress
//   done             one-cycle pulse after the last result is accepted
// ----------------------------------------------------------------------------
module instr_exec_unit #(
    parameter int ADDR_W = 5,
    parameter int OP_W   = 32,
    parameter int RES_W  = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       first_addr,
    input  logic [ADDR_W:0]         count,
    output logic [ADDR_W-1:0]       read_pointer,
    input  logic [2*OP_W+2:0]       instruction_word,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [RES_W-1:0] res_data,
    output logic [ADDR_W-1:0]       res_addr,
    output logic                    res_err,
    output logic                    busy,
    output logic                    done
);

    localparam int IW_W  = 2*OP_W + 3;
    localparam int CNT_W = $clog2(OP_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);

    localparam logic [2:0] OPC_ZERO  = 3'd0;
    localparam logic [2:0] OPC_PASSA = 3'd1;
    localparam logic [2:0] OPC_PASSB = 3'd2;
    localparam logic [2:0] OPC_ADD   = 3'd3;
    localparam logic [2:0] OPC_SUB   = 3'd4;
    localparam logic [2:0] OPC_MULT  = 3'd5;
    localparam logic [2:0] OPC_DIV   = 3'd6;
    localparam logic [2:0] OPC_MOD   = 3'd7;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, DIVIDE, OUTPUT} state_t;

    state_t                   state;
    logic [ADDR_W-1:0]        cur;
    logic [ADDR_W:0]          rem;
    logic [IW_W-1:0]          iw_q;
    logic signed [RES_W-1:0]  res_q;
    logic                     err_q;
    logic                     done_q;

    // divider state: partial remainder, dividend/quotient shift register
    logic [OP_W:0]            prem_q;
    logic [OP_W-1:0]          quo_q;
    logic [OP_W-1:0]          dvs_q;
    logic [CNT_W-1:0]         div_cnt;
    logic                     q_neg;
    logic                     r_neg;
    logic                     is_mod;

    // sign-extend an operand to result width
    function automatic logic signed [RES_W-1:0] sext(input logic [OP_W-1:0] v);
        return $signed({{(RES_W-OP_W){v[OP_W-1]}}, v});
    endfunction

    // magnitude of a two's-complement operand; the most negative value maps
    // to 2**(OP_W-1), which still fits as unsigned
    function automatic logic [OP_W-1:0] mag(input logic [OP_W-1:0] v);
        return v[OP_W-1] ? (~v + OP_W'(1)) : v;
    endfunction

    // one restoring-division step: returns {next partial remainder, next quotient}
    function automatic logic [2*OP_W:0] div_step(input logic [OP_W:0]   prem,
                                                 input logic [OP_W-1:0] quo,
                                                 input logic [OP_W-1:0] dvs);
        logic [OP_W:0] shifted;
        logic [OP_W:0] trial;
        shifted = {prem[OP_W-1:0], quo[OP_W-1]};
        trial   = shifted - {1'b0, dvs};
        if (!trial[OP_W])
            return {trial, quo[OP_W-2:0], 1'b1};
        else
            return {shifted, quo[OP_W-2:0], 1'b0};
    endfunction

    // apply the sign to an unsigned magnitude, widening to result width
    function automatic logic signed [RES_W-1:0] apply_sign(input logic [OP_W-1:0] m,
                                                           input logic neg);
        logic signed [RES_W-1:0] e;
        e = $signed({{(RES_W-OP_W){1'b0}}, m});
        return neg ? -e : e;
    endfunction

    logic [2:0]               opc;
    logic [OP_W-1:0]          op_a;
    logic [OP_W-1:0]          op_b;
    logic signed [RES_W-1:0]  a_ext;
    logic signed [RES_W-1:0]  b_ext;
    logic [2*OP_W:0]          step;
    logic [OP_W:0]            step_rem;
    logic [OP_W-1:0]          step_quo;

    assign opc      = iw_q[IW_W-1 -: 3];
    assign op_a     = iw_q[2*OP_W-1 -: OP_W];
    assign op_b     = iw_q[OP_W-1:0];
    assign a_ext    = sext(op_a);
    assign b_ext    = sext(op_b);
    assign step     = div_step(prem_q, quo_q, dvs_q);
    assign step_rem = step[2*OP_W -: OP_W+1];
    assign step_quo = step[OP_W-1:0];

    // every output is a register or a decode of the state register
    assign read_pointer = cur;
    assign res_addr     = cur;
    assign res_data     = res_q;
    assign res_err      = err_q;
    assign res_valid    = (state == OUTPUT);
    assign busy         = (state != IDLE);
    assign done         = done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cur     <= '0;
            rem     <= '0;
            iw_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            prem_q  <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            div_cnt <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            is_mod  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cur <= first_addr;
                        rem <= count;
                        if (count == '0)
                            done_q <= 1'b1;
                        else
                            state <= FETCH;
                    end
                end

                FETCH: begin
                    iw_q  <= instruction_word;
                    state <= EXEC;
                end

                EXEC: begin
                    err_q <= 1'b0;
                    state <= OUTPUT;
                    case (opc)
                        OPC_ZERO:  res_q <= '0;
                        OPC_PASSA: res_q <= a_ext;
                        OPC_PASSB: res_q <= b_ext;
                        OPC_ADD:   res_q <= a_ext + b_ext;
                        OPC_SUB:   res_q <= a_ext - b_ext;
                        OPC_MULT:  res_q <= a_ext * b_ext;
                        OPC_DIV, OPC_MOD: begin
                            if (op_b == '0) begin
                                res_q <= '0;
                                err_q <= 1'b1;
                            end else begin
                                prem_q  <= '0;
                                quo_q   <= mag(op_a);
                                dvs_q   <= mag(op_b);
                                q_neg   <= op_a[OP_W-1] ^ op_b[OP_W-1];
                                r_neg   <= op_a[OP_W-1];
                                is_mod  <= (opc == OPC_MOD);
                                div_cnt <= '0;
                                state   <= DIVIDE;
                            end
                        end
                        default:   res_q <= '0;
                    endcase
                end

                DIVIDE: begin
                    prem_q  <= step_rem;
                    quo_q   <= step_quo;
                    div_cnt <= div_cnt + CNT_W'(1);
                    // final step: take the result straight from this step's output
                    if (div_cnt == CNT_LAST) begin
                        res_q <= is_mod ? apply_sign(step_rem[OP_W-1:0], r_neg)
                                        : apply_sign(step_quo, q_neg);
                        state <= OUTPUT;
                    end
                end

                OUTPUT: begin
                    if (res_ready) begin
                        rem <= rem - (ADDR_W+1)'(1);
                        if (rem == (ADDR_W+1)'(1)) begin
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            cur   <= cur + ADDR_W'(1);
                            state <= FETCH;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
